// File: rtl/uart_tx.sv
// UART transmitter: takes bytes from the upstream FIFO over a req/ack handshake
// and shifts them out LSB first with optional parity and one or two stop bits.
module uart_tx #(
   parameter int dw        = 8,
   parameter int CLK_DIV   = 868,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [dw-1:0] d_in,
   input  logic          req_in,
   output logic          ack_in,
   output logic          txd,
   output logic          busy,
   output logic          tx_done
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(dw);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(dw - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_baud;
   logic [BW-1:0]   r_bit;
   logic [dw-1:0]   r_shift;
   logic            r_parity;
   logic            r_txd;
   logic            r_done;
   logic            w_bitEnd;

   assign w_bitEnd = (r_baud == BAUD_LAST);

   assign ack_in  = (r_state == S_IDLE);
   assign busy    = (r_state != S_IDLE);
   assign txd     = r_txd;
   assign tx_done = r_done;

   // r_bit counts data bits in DATA and is reused to count stop bits in STOP.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_txd    <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state != S_IDLE) begin
            r_baud <= w_bitEnd ? '0 : r_baud + CW'(1);
         end
         case (r_state)
            S_IDLE: begin
               r_baud <= '0;
               r_bit  <= '0;
               r_txd  <= 1'b1;
               if (req_in) begin
                  r_shift  <= d_in;
                  r_parity <= (PARITY == 2) ? ~(^d_in) : (^d_in);
                  r_txd    <= 1'b0;
                  r_state  <= S_START;
               end
            end
            S_START: begin
               if (w_bitEnd) begin
                  r_txd   <= r_shift[0];
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_bitEnd) begin
                  if (r_bit == DATA_LAST) begin
                     r_bit <= '0;
                     if (PARITY != 0) begin
                        r_txd   <= r_parity;
                        r_state <= S_PARITY;
                     end else begin
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                     end
                  end else begin
                     r_bit   <= r_bit + BW'(1);
                     r_shift <= r_shift >> 1;
                     r_txd   <= r_shift[1];
                  end
               end
            end
            S_PARITY: begin
               if (w_bitEnd) begin
                  r_txd   <= 1'b1;
                  r_state <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_bitEnd) begin
                  if (r_bit == STOP_LAST) begin
                     r_bit   <= '0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_bit <= r_bit + BW'(1);
                  end
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains bytes from the FIFO output port and sends them as asynchronous UART frames on a single line. It sits directly downstream of the FIFO: the FIFO's `d_out`/`req_out` drive this block's `d_in`/`req_in`, and this block's `ack_in` drives the FIFO's `ack_out`. The block provides a programmable bit period, optional parity and one or two stop bits.

## Interface
- `dw`, 8: data bits per frame, 5..9.
- `CLK_DIV`, 868: clock cycles per serial bit, ≥2. 868 gives 115200 baud at 100 MHz.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `d_in`  in  dw  byte to send; sampled only on a handshake edge.
- `req_in`  in  1  upstream has valid data.
- `ack_in`  out  1  block can accept a byte (high only in IDLE).
- `txd`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress (any state other than IDLE).
- `tx_done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- States: IDLE → START → DATA → PARITY (skipped when `PARITY`=0) → STOP → IDLE.
- Handshake:
  - A transfer occurs on a rising edge where `req_in & ack_in` = 1.
  - `ack_in` is decoded from state only (`state==IDLE`). There is no combinational path from `req_in` to `ack_in`.
- On a transfer edge:
  - `d_in` is latched into the shift register.
  - Parity is computed from the latched byte: even = XOR of the bits, odd = its inverse.
  - The state moves to START, and the baud counter and bit counter clear.
  - After this edge the block ignores `d_in` and `req_in` until it is back in IDLE.
- Each non-IDLE bit lasts exactly `CLK_DIV` cycles, timed by the baud counter.
  - The baud counter runs 0..`CLK_DIV`-1 and is $clog2(`CLK_DIV`) bits wide.
  - A bit ends when the counter reaches `CLK_DIV`-1; the counter then wraps to 0.
- Line values by state:
  - START drives `txd`=0.
  - DATA sends the `dw` bits LSB first, shifting right once per bit. The bit counter ($clog2(`dw`) bits) exits DATA at `dw`-1.
  - PARITY drives the parity bit.
  - STOP drives `txd`=1 for `STOP_BITS`×`CLK_DIV` cycles.
- `txd` is a registered output. It never glitches and always reflects the current state's bit.
- When the final stop cycle ends:
  - the state moves to IDLE;
  - `tx_done`=1 for exactly that following cycle.
- `busy` = (state≠IDLE), registered-state decode.
- Reset mid-frame:
  - `txd` returns to 1 asynchronously, the state goes to IDLE and the frame is aborted.
  - The aborted byte is lost, which is acceptable because the FIFO is reset on the same net.

## Timing
- Reset values: `txd`=1, `busy`=0, `tx_done`=0, `ack_in`=1 (IDLE). All counters are 0.
- Handshake on edge E: the start bit appears on `txd` in the cycle after E and lasts `CLK_DIV` cycles.
- Frame length F = `CLK_DIV`×(1 + `dw` + (`PARITY`≠0) + `STOP_BITS`) cycles, counted from edge E.
- At edge E+F:
  - the state becomes IDLE;
  - `ack_in`=1 and `tx_done`=1 in cycle E+F.
- The earliest next handshake is edge E+F+1 if `req_in` is high. With `req_in` held high, frames repeat with a fixed gap of exactly one idle-high cycle.
- `req_in` low in IDLE: the block stays IDLE with `txd`=1 and does not consume.
- `ack_in` is low for all of START..STOP.

## Test plan
Bench uses `CLK_DIV`=4, `dw`=8 unless stated otherwise.

- **Reset idle:** hold `rstn`=0, then release with `req_in`=0 for 50 cycles → `txd`=1, `ack_in`=1, `busy`=0, `tx_done`=0 throughout.
- **Single byte, no parity:** send 0xA5.
  - Line sequence: start 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop 1 for 4 cycles.
  - `tx_done` pulses at cycle 40 after the handshake.
- **Even/odd parity:** send 0x07 with `PARITY`=1 → parity bit 1; with `PARITY`=2 → parity bit 0. F=44 cycles.
- **Back-to-back from FIFO:** wire to the FIFO (`L`=7), preload 0x11, 0x22, 0x33.
  - Three frames emitted in order, separated by exactly 1 idle cycle.
  - FIFO `req_out` drops after the third handshake.
- **Two stop bits:** `STOP_BITS`=2 → stop high for 8 cycles, F=44.
- **Reset mid-frame:** assert `rstn` during DATA bit 3 → `txd`=1 immediately and `busy`=0. After release, a new byte 0x3C transmits correctly.
